mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 30 +++
 rtl/mem_lsu_if.sv | 22 ++
 rtl/mem_lsu_align.sv | 73 +++++++
 rtl/mem_lsu.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared memory-op encodings, access sizes and LSU state enum
package mem_lsu_pkg;

    localparam int MemOpBus = 4;

    typedef enum logic [MemOpBus-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - LSU data bus bundle with master (LSU) and slave (memory) views
interface mem_lsu_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_ack_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_ack_i, bus_rdata_i
    );

endinterface

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - big-endian lane select, store replication and load extension
module mem_align
    import mem_lsu_pkg::*;
(
    input  logic [MemOpBus-1:0] op_i,
    input  logic [1:0]          off_i,
    input  logic [31:0]         sdata_i,
    input  logic [31:0]         rdata_i,
    output logic                is_mem_o,
    output logic                is_store_o,
    output logic                misalign_o,
    output logic [3:0]          sel_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         ldata_o
);

    mem_size_e   size;
    logic        sign_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b0;
        size       = SZ_BYTE;
        sign_ext   = 1'b0;
        case (op_i)
            OP_LB:   sign_ext = 1'b1;
            OP_LBU:  size = SZ_BYTE;
            OP_LH:   begin size = SZ_HALF; sign_ext = 1'b1; end
            OP_LHU:  size = SZ_HALF;
            OP_LW:   size = SZ_WORD;
            OP_SB:   is_store_o = 1'b1;
            OP_SH:   begin size = SZ_HALF; is_store_o = 1'b1; end
            OP_SW:   begin size = SZ_WORD; is_store_o = 1'b1; end
            default: is_mem_o = 1'b0;
        endcase
    end

    // Byte 0 of a word lives in bits 31:24.
    always_comb begin
        case (off_i)
            2'd0:    byte_lane = rdata_i[31:24];
            2'd1:    byte_lane = rdata_i[23:16];
            2'd2:    byte_lane = rdata_i[15:8];
            default: byte_lane = rdata_i[7:0];
        endcase
        half_lane = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    always_comb begin
        misalign_o = 1'b0;
        sel_o      = 4'b1111;
        wdata_o    = sdata_i;
        ldata_o    = rdata_i;
        case (size)
            SZ_BYTE: begin
                sel_o   = 4'b1000 >> off_i;
                wdata_o = {4{sdata_i[7:0]}};
                ldata_o = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                misalign_o = off_i[0];
                sel_o      = off_i[1] ? 4'b0011 : 4'b1100;
                wdata_o    = {2{sdata_i[15:0]}};
                ldata_o    = {{16{sign_ext & half_lane[15]}}, half_lane};
            end
            default: misalign_o = |off_i;
        endcase
        misalign_o = misalign_o & is_mem_o;
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: stalls the pipeline around one bus access
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          mem_wd_i,
    input  logic                mem_wreg_i,
    input  logic [31:0]         mem_wdata_i,
    input  logic                mem_whilo_i,
    input  logic [31:0]         mem_hi_i,
    input  logic [31:0]         mem_lo_i,
    input  logic [MemOpBus-1:0] mem_op_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [31:0]         mem_sdata_i,
    output logic [4:0]          wb_wd_o,
    output logic                wb_wreg_o,
    output logic [31:0]         wb_wdata_o,
    output logic                wb_whilo_o,
    output logic [31:0]         wb_hi_o,
    output logic [31:0]         wb_lo_o,
    output logic                stallreq_o,
    output logic                align_err_o,
    mem_lsu_if.master           bus
);

    lsu_state_e          state_q, state_d;
    logic [MemOpBus-1:0] op_q;
    logic [1:0]          off_q;
    logic                bus_req_q, bus_we_q;
    logic [31:0]         bus_addr_q, bus_wdata_q, load_data_q;
    logic [3:0]          bus_sel_q;
    logic                launch;

    logic [MemOpBus-1:0] al_op;
    logic [1:0]          al_off;
    logic                al_is_mem, al_is_store, al_misalign;
    logic [3:0]          al_sel;
    logic [31:0]         al_wdata, al_ldata;

    // Decode live inputs while idle; the latched op drives load extension during the access.
    assign al_op  = (state_q == ST_IDLE) ? mem_op_i : op_q;
    assign al_off = (state_q == ST_IDLE) ? mem_addr_i[1:0] : off_q;

    mem_align u_align (
        .op_i       (al_op),
        .off_i      (al_off),
        .sdata_i    (mem_sdata_i),
        .rdata_i    (bus.bus_rdata_i),
        .is_mem_o   (al_is_mem),
        .is_store_o (al_is_store),
        .misalign_o (al_misalign),
        .sel_o      (al_sel),
        .wdata_o    (al_wdata),
        .ldata_o    (al_ldata)
    );

    assign wb_wd_o    = mem_wd_i;
    assign wb_whilo_o = mem_whilo_i;
    assign wb_hi_o    = mem_hi_i;
    assign wb_lo_o    = mem_lo_i;

    assign bus.bus_req_o   = bus_req_q;
    assign bus.bus_we_o    = bus_we_q;
    assign bus.bus_addr_o  = bus_addr_q;
    assign bus.bus_sel_o   = bus_sel_q;
    assign bus.bus_wdata_o = bus_wdata_q;

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        stallreq_o  = 1'b0;
        align_err_o = 1'b0;
        wb_wreg_o   = mem_wreg_i;
        wb_wdata_o  = mem_wdata_i;
        case (state_q)
            ST_IDLE: begin
                if (al_is_mem) begin
                    wb_wreg_o = 1'b0;
                    if (al_misalign) begin
                        align_err_o = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                        launch     = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stallreq_o = 1'b1;
                wb_wreg_o  = 1'b0;
                if (bus.bus_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus_we_q) begin
                    wb_wdata_o = load_data_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) begin
            stallreq_o  = 1'b0;
            align_err_o = 1'b0;
            wb_wreg_o   = 1'b0;
            launch      = 1'b0;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                op_q        <= mem_op_i;
                off_q       <= mem_addr_i[1:0];
                bus_req_q   <= 1'b1;
                bus_we_q    <= al_is_store;
                bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
                bus_sel_q   <= al_sel;
                bus_wdata_q <= al_wdata;
            end
            if (state_q == ST_REQ && bus.bus_ack_i) begin
                bus_req_q <= 1'b0;
                if (!bus_we_q) begin
                    load_data_q <= al_ldata;
                end
            end
        end
    end

endmodule
